// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 mouse receiver:
//   bit_state_t    - per-frame bit FSM states (IDLE/DATA/PARITY/STOP)
//   pkt_state_t    - 3-byte movement packet FSM states (BYTE0/BYTE1/BYTE2)
//   PS2_FRAME_BITS - bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_PKT_BYTES  - bytes per standard movement packet
//   MOUSE_*        - field positions inside the 25-bit ps2_mouse word
//   odd_parity_ok  - true when data plus parity bit carry odd parity
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_DATA,
        BIT_PARITY,
        BIT_STOP
    } bit_state_t;

    typedef enum logic [1:0] {
        PKT_BYTE0,
        PKT_BYTE1,
        PKT_BYTE2
    } pkt_state_t;

    localparam int PS2_FRAME_BITS   = 11;
    localparam int PS2_DATA_BITS    = PS2_FRAME_BITS - 3;
    localparam int PS2_PKT_BYTES    = 3;

    localparam int MOUSE_STATUS_LSB = 0;
    localparam int MOUSE_X_LSB      = 8;
    localparam int MOUSE_Y_LSB      = 16;
    localparam int MOUSE_STROBE_BIT = 24;
    localparam int MOUSE_WIDTH      = 25;

    // Status byte bit that is always set in a genuine first packet byte.
    localparam int MOUSE_SYNC_BIT   = 3;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// -----------------------------------------------------------------------------
// ps2_byte_rx
// Receives one 11-bit device-to-host PS/2 frame at a time.
// Synchronises both pins, detects falling edges of the PS/2 clock (optionally
// through a stability filter when PS2_MOUSE_FILTER_EN is defined), runs the
// bit FSM and checks start, odd parity and stop bits.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   ps2_clk_in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  raw PS/2 data pin (asynchronous)
//   abort        return the bit FSM to IDLE this cycle (timeout)
//   clk_fall     one-clk pulse per accepted PS/2 clock falling edge
//   bit_idle     bit FSM is in IDLE
//   byte_valid   one-clk pulse, byte_data holds a correctly framed byte
//   byte_data    received byte, D0 in bit 0
//   byte_err     one-clk pulse on a bad start, parity or stop bit
// -----------------------------------------------------------------------------
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       abort,
    output logic       clk_fall,
    output logic       bit_idle,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    // Synchronisers idle high, matching the released open-collector lines.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_s;
    logic       data_s;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

`ifdef PS2_MOUSE_FILTER_EN
    // A new level is accepted only after it has differed from the last
    // accepted level for FILTER_LEN consecutive clks; shorter glitches vanish.
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    logic              clk_lvl;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_take;

    assign filt_take = (clk_s != clk_lvl) && (filt_cnt == FILT_LAST);
    assign clk_fall  = filt_take && !clk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_lvl  <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_lvl) begin
            filt_cnt <= '0;
        end else if (filt_take) begin
            clk_lvl  <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    logic clk_prev;

    assign clk_fall = clk_prev && !clk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s;
        end
    end
`endif

    bit_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       parity_q, parity_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BIT_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;

        if (abort) begin
            state_d = BIT_IDLE;
        end else if (clk_fall) begin
            case (state_q)
                BIT_IDLE: begin
                    if (!data_s) begin
                        state_d   = BIT_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        byte_err  = 1'b1;
                    end
                end
                BIT_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shreg_d = {data_s, shreg_q[7:1]};
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = BIT_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                BIT_PARITY: begin
                    parity_d = data_s;
                    state_d  = BIT_STOP;
                end
                BIT_STOP: begin
                    state_d = BIT_IDLE;
                    if (data_s && odd_parity_ok(shreg_q, parity_q)) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err   = 1'b1;
                    end
                end
                default: state_d = BIT_IDLE;
            endcase
        end
    end

    assign byte_data = shreg_q;
    assign bit_idle  = (state_q == BIT_IDLE);

endmodule

// File: rtl/ps2_mouse_rx.sv
// -----------------------------------------------------------------------------
// ps2_mouse_rx
// Device-to-host PS/2 mouse receiver. Assembles 3-byte movement packets from
// ps2_byte_rx and publishes them as the 25-bit ps2_mouse word. Receive only.
// Optional clock-edge filter: define PS2_MOUSE_FILTER_EN.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   ps2_clk_in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  raw PS/2 data pin (asynchronous)
//   ps2_mouse    [7:0] status, [15:8] X, [23:16] Y, [24] one-clk new-packet strobe
//   frame_err    one-clk pulse on start/parity/stop error or timeout abort
// -----------------------------------------------------------------------------
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 42954
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps2_clk_in,
    input  logic                   ps2_data_in,
    output logic [MOUSE_WIDTH-1:0] ps2_mouse,
    output logic                   frame_err
);

    if (PS2_PKT_BYTES != 3) begin : g_bad_pkt_len
        $error("packet FSM is written for 3-byte packets");
    end

    logic       clk_fall;
    logic       bit_idle;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       timeout_hit;

    ps2_byte_rx #(
        .FILTER_LEN (FILTER_LEN)
    ) u_byte_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .abort       (timeout_hit),
        .clk_fall    (clk_fall),
        .bit_idle    (bit_idle),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_err    (byte_err)
    );

    // Idle counter: cleared by each accepted edge, saturates at the limit.
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt_q;
    pkt_state_t        pkt_q, pkt_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic              publish;
    logic              pkt_err;

    // Suppressed on an edge cycle, so a timeout can never coincide with a
    // byte completing (and hence never with a publish).
    assign timeout_hit = (idle_cnt_q == IDLE_MAX) && !clk_fall &&
                         (!bit_idle || pkt_q != PKT_BYTE0);

    always_comb begin
        pkt_d   = pkt_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        publish = 1'b0;
        pkt_err = 1'b0;

        if (timeout_hit || byte_err) begin
            pkt_d   = PKT_BYTE0;
            pkt_err = 1'b1;
        end else if (byte_valid) begin
            case (pkt_q)
                PKT_BYTE0: begin
                    // A first byte without the sync bit is a misaligned
                    // stream; drop it quietly and keep hunting.
                    if (byte_data[MOUSE_SYNC_BIT]) begin
                        b0_d  = byte_data;
                        pkt_d = PKT_BYTE1;
                    end
                end
                PKT_BYTE1: begin
                    b1_d  = byte_data;
                    pkt_d = PKT_BYTE2;
                end
                PKT_BYTE2: begin
                    publish = 1'b1;
                    pkt_d   = PKT_BYTE0;
                end
                default: pkt_d = PKT_BYTE0;
            endcase
        end
    end

    // NOTE: the partial-packet byte registers are reset as well, so nothing
    // from before a reset can leak into a later packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q      <= PKT_BYTE0;
            b0_q       <= '0;
            b1_q       <= '0;
            idle_cnt_q <= '0;
            ps2_mouse  <= '0;
            frame_err  <= 1'b0;
        end else begin
            pkt_q     <= pkt_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            frame_err <= pkt_err;

            if (clk_fall) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end

            ps2_mouse[MOUSE_STROBE_BIT] <= publish;
            if (publish) begin
                ps2_mouse[MOUSE_STATUS_LSB +: 8] <= b0_q;
                ps2_mouse[MOUSE_X_LSB      +: 8] <= b1_q;
                ps2_mouse[MOUSE_Y_LSB      +: 8] <= byte_data;
            end
        end
    end

endmodule
